// File: rtl/leaf_parent_responder.sv
// Leaf-side endpoint of the root-hub parent link: decodes command words, runs and times
// decodes, streams the result RAM and answers pings over a registered valid/ready uplink.
module leaf_parent_responder #(
  parameter int FPGA_ID          = 1,
  parameter int NUM_CONTEXTS     = 2,
  parameter int NUM_RESULT_WORDS = 64,
  localparam int CTX_W  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
  localparam int ADDR_W = (NUM_RESULT_WORDS > 1) ? $clog2(NUM_RESULT_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       parent_rx_data,
  input  logic              parent_rx_valid,
  output logic              parent_rx_ready,
  output logic [63:0]       parent_tx_data,
  output logic              parent_tx_valid,
  input  logic              parent_tx_ready,
  output logic              decode_start,
  output logic [CTX_W-1:0]  decode_context,
  input  logic              decode_done,
  output logic              result_rd_en,
  output logic [ADDR_W-1:0] result_rd_addr,
  input  logic [31:0]       result_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DONE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_SEND,
    S_SEND
  } state_t;

  localparam logic [7:0] MY_ID    = 8'(FPGA_ID);
  localparam logic [6:0] LAST_IDX = 7'(NUM_RESULT_WORDS - 1);

  state_t      state;
  logic [6:0]  rd_idx;
  logic [31:0] cycle_cnt;

  logic [7:0]  rx_op;
  logic [7:0]  rx_dest;
  logic [39:0] rx_payload;
  logic        accept;
  logic        for_me;
  logic        tx_fire;
  logic        unused_src;

  assign rx_op      = parent_rx_data[63:56];
  assign rx_dest    = parent_rx_data[55:48];
  assign rx_payload = parent_rx_data[39:0];
  assign unused_src = ^parent_rx_data[47:40];
  assign accept     = parent_rx_valid & parent_rx_ready;
  assign for_me     = (rx_dest == MY_ID) || (rx_dest == 8'hFF);
  assign tx_fire    = parent_tx_valid & parent_tx_ready;

  function automatic logic [63:0] resp_word(input logic [7:0] op, input logic [39:0] payload);
    return {op, 8'h00, MY_ID, payload};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      parent_rx_ready <= 1'b0;
      parent_tx_data  <= '0;
      parent_tx_valid <= 1'b0;
      decode_start    <= 1'b0;
      decode_context  <= '0;
      result_rd_en    <= 1'b0;
      result_rd_addr  <= '0;
      rd_idx          <= '0;
      cycle_cnt       <= '0;
    end else begin
      decode_start    <= 1'b0;
      result_rd_en    <= 1'b0;
      // Ready drops right after an accept so a second word is never taken while busy.
      parent_rx_ready <= (state == S_IDLE) && !accept;
      case (state)
        S_IDLE: begin
          if (accept && for_me) begin
            case (rx_op)
              8'h01: begin
                decode_start   <= 1'b1;
                decode_context <= rx_payload[CTX_W-1:0];
                cycle_cnt      <= '0;
                state          <= S_WAIT_DONE;
              end
              8'h02: begin
                rd_idx         <= '0;
                result_rd_en   <= 1'b1;
                result_rd_addr <= '0;
                state          <= S_RD_REQ;
              end
              8'h03: begin
                parent_tx_data  <= resp_word(8'h83, rx_payload);
                parent_tx_valid <= 1'b1;
                state           <= S_SEND;
              end
              default: begin
                parent_tx_data  <= resp_word(8'hFF, {32'h0, rx_op});
                parent_tx_valid <= 1'b1;
                state           <= S_SEND;
              end
            endcase
          end
        end
        S_WAIT_DONE: begin
          // A done coincident with the start pulse belongs to an earlier job.
          if (decode_done && !decode_start) begin
            parent_tx_data  <= resp_word(8'h84, {8'(decode_context), cycle_cnt});
            parent_tx_valid <= 1'b1;
            state           <= S_SEND;
          end else begin
            cycle_cnt <= sat_inc(cycle_cnt);
          end
        end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          parent_tx_data  <= resp_word(8'h82, {(rd_idx == LAST_IDX), rd_idx, result_rd_data});
          parent_tx_valid <= 1'b1;
          state           <= S_RD_SEND;
        end
        S_RD_SEND: begin
          if (tx_fire) begin
            parent_tx_valid <= 1'b0;
            if (rd_idx == LAST_IDX) begin
              state <= S_IDLE;
            end else begin
              rd_idx         <= rd_idx + 7'd1;
              result_rd_en   <= 1'b1;
              result_rd_addr <= ADDR_W'(rd_idx + 7'd1);
              state          <= S_RD_REQ;
            end
          end
        end
        S_SEND: begin
          if (tx_fire) begin
            parent_tx_valid <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_parent_responder.sv
// Directed bench for leaf_parent_responder: ping, timed decode, result streaming with
// back-pressure, address filtering, unknown opcodes and reset during a read burst.
module tb_leaf_parent_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        decode_start;
  logic [0:0]  decode_context;
  logic        decode_done;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int start_pulses = 0;

  always #5 clk = ~clk;

  leaf_parent_responder #(
    .FPGA_ID(1),
    .NUM_CONTEXTS(2),
    .NUM_RESULT_WORDS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .parent_rx_data(rx_data),
    .parent_rx_valid(rx_valid),
    .parent_rx_ready(rx_ready),
    .parent_tx_data(tx_data),
    .parent_tx_valid(tx_valid),
    .parent_tx_ready(tx_ready),
    .decode_start(decode_start),
    .decode_context(decode_context),
    .decode_done(decode_done),
    .result_rd_en(rd_en),
    .result_rd_addr(rd_addr),
    .result_rd_data(rd_data)
  );

  // Result RAM model: RAM[i] = 0xA0 + i, one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= 32'hA0 + 32'(rd_addr);
  end

  always @(posedge clk) begin
    if (reset && decode_start) start_pulses <= start_pulses + 1;
  end

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [63:0] w);
    logic done_flag;
    done_flag = 1'b0;
    rx_data  = w;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done_flag; i++) begin
      if (rx_ready) done_flag = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!done_flag) check64("rx_accept_timeout", {63'b0, rx_ready}, 64'd1);
  endtask

  task automatic expect_tx(input string tag, input logic [63:0] exp);
    logic seen;
    seen = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (tx_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (seen) begin
      check64(tag, tx_data, exp);
      @(negedge clk);
      check64({tag, "_valid_drop"}, {63'b0, tx_valid}, 64'd0);
    end else begin
      check64({tag, "_timeout"}, {63'b0, tx_valid}, 64'd1);
    end
  endtask

  initial begin
    logic [63:0] exp_rd [4];
    logic [63:0] held;
    logic        stalled;
    logic        tgl;
    logic        seen;
    logic        found;
    int          k;

    reset = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; decode_done = 1'b0;
    #12;
    check64("rst_rx_ready", {63'b0, rx_ready}, 64'd0);
    check64("rst_tx_valid", {63'b0, tx_valid}, 64'd0);
    check64("rst_tx_data", tx_data, 64'd0);
    check64("rst_ctl", {59'b0, decode_start, decode_context, rd_en, rd_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check64("ready_after_reset", {63'b0, rx_ready}, 64'd1);

    // Ping addressed to this leaf
    send_cmd({8'h03, 8'h01, 8'h00, 40'h12_3456_789A});
    expect_tx("ping", 64'h8300_0112_3456_789A);
    @(negedge clk);
    check64("ready_after_ping", {63'b0, rx_ready}, 64'd1);

    // Timed decode: done 5 cycles after start
    send_cmd({8'h01, 8'h01, 8'h00, 40'h1});
    check64("start_pulse", {63'b0, decode_start}, 64'd1);
    check64("start_ctx", {63'b0, decode_context}, 64'd1);
    repeat (5) @(negedge clk);
    decode_done = 1'b1;
    @(negedge clk);
    decode_done = 1'b0;
    expect_tx("done_ctx1", 64'h8400_0101_0000_0005);
    check64("start_once", 64'(start_pulses), 64'd1);

    // Done coincident with start is ignored; real done 3 cycles later
    send_cmd({8'h01, 8'h01, 8'h00, 40'h0});
    decode_done = 1'b1;
    @(negedge clk);
    decode_done = 1'b0;
    check64("done_with_start_ignored", {63'b0, tx_valid}, 64'd0);
    repeat (2) @(negedge clk);
    decode_done = 1'b1;
    @(negedge clk);
    decode_done = 1'b0;
    expect_tx("done_ctx0", 64'h8400_0100_0000_0003);

    // Done while idle is ignored
    @(negedge clk);
    decode_done = 1'b1;
    @(negedge clk);
    decode_done = 1'b0;
    @(negedge clk);
    check64("idle_done_ignored", {62'b0, tx_valid, rx_ready}, 64'd1);

    // Read burst with toggling back-pressure
    exp_rd[0] = 64'h8200_0100_0000_00A0;
    exp_rd[1] = 64'h8200_0101_0000_00A1;
    exp_rd[2] = 64'h8200_0102_0000_00A2;
    exp_rd[3] = 64'h8200_0183_0000_00A3;
    send_cmd({8'h02, 8'h01, 8'h00, 40'h0});
    k = 0; stalled = 1'b0; tgl = 1'b0; held = '0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      if (stalled) begin
        check64("rd_stall_valid", {63'b0, tx_valid}, 64'd1);
        check64("rd_stall_hold", tx_data, held);
        stalled = 1'b0;
      end
      tgl = ~tgl;
      tx_ready = tgl;
      if (tx_valid) begin
        if (tx_ready) begin
          check64($sformatf("rd_word%0d", k), tx_data, exp_rd[k]);
          k++;
        end else begin
          held = tx_data;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
    end
    check64("rd_word_count", 64'(k), 64'd4);
    tx_ready = 1'b1;
    check64("rd_end_valid_drop", {63'b0, tx_valid}, 64'd0);
    repeat (2) @(negedge clk);
    check64("ready_after_read", {63'b0, rx_ready}, 64'd1);

    // Foreign destination consumed silently, broadcast answered
    send_cmd({8'h03, 8'h07, 8'h00, 40'h5});
    seen = 1'b0;
    repeat (6) begin
      seen = seen | tx_valid;
      @(negedge clk);
    end
    check64("foreign_no_tx", {63'b0, seen}, 64'd0);
    check64("foreign_ready", {63'b0, rx_ready}, 64'd1);
    send_cmd({8'h03, 8'hFF, 8'h00, 40'hAB});
    expect_tx("broadcast_ping", 64'h8300_0100_0000_00AB);
    @(negedge clk);

    // Unknown opcode
    send_cmd({8'h55, 8'h01, 8'h00, 40'h0});
    expect_tx("unknown_op", 64'hFF00_0100_0000_0055);
    @(negedge clk);

    // Reset while word idx 2 is pending
    send_cmd({8'h02, 8'h01, 8'h00, 40'h0});
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (tx_valid && tx_data[38:32] == 7'd2) begin
        tx_ready = 1'b0;
        found = 1'b1;
      end else begin
        tx_ready = 1'b1;
        @(negedge clk);
      end
    end
    check64("rd_idx2_reached", {63'b0, found}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check64("midrst_tx_valid", {63'b0, tx_valid}, 64'd0);
    check64("midrst_tx_data", tx_data, 64'd0);
    check64("midrst_ctl", {62'b0, rx_ready, rd_en}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check64("postrst_idle", {62'b0, tx_valid, rx_ready}, 64'd1);
    send_cmd({8'h03, 8'h01, 8'h00, 40'h77});
    expect_tx("postrst_ping", 64'h8300_0100_0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
